// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the 64-bit ALU interface.
// Takes one LEGv8 instruction and its two operands over a valid/ready
// handshake, decodes the opcode to an ALU control code and drives the ALU
// operand buses for a fixed settle window. It then captures BusW/Zero and
// returns them over an output valid/ready handshake.
module alu_issue_ctrl #(
  parameter int n             = 64,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         CLK,
  input  logic         resetl,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [10:0]  Opcode,
  input  logic [n-1:0] OpA,
  input  logic [n-1:0] OpB,
  output logic [3:0]   ALUCtrl,
  output logic [n-1:0] AluA,
  output logic [n-1:0] AluB,
  input  logic [n-1:0] AluW,
  input  logic         AluZero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] Result,
  output logic         ResultZero,
  output logic         BranchTaken,
  output logic         Illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] CTRL_AND   = 4'b0000;
  localparam logic [3:0] CTRL_OR    = 4'b0001;
  localparam logic [3:0] CTRL_ADD   = 4'b0010;
  localparam logic [3:0] CTRL_SUB   = 4'b0110;
  localparam logic [3:0] CTRL_PASSB = 4'b0111;

  // Counter is loaded with SETTLE_CYCLES-1 so EXEC lasts SETTLE_CYCLES edges.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] cnt;
  logic       cbz_q;
  logic [3:0] dec_ctrl;
  logic       dec_legal;
  logic       dec_cbz;
  logic       accept;
  logic       exec_done;

  assign accept    = in_valid & in_ready;
  assign exec_done = (state == EXEC) && (cnt == 4'd0);

  // Opcode decode: ALU control code, legality and the CBZ marker.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    dec_ctrl  = CTRL_AND;
    dec_legal = 1'b1;
    dec_cbz   = 1'b0;
    casez (Opcode)
      11'b10001011000: dec_ctrl = CTRL_ADD;   // ADD
      11'b11001011000: dec_ctrl = CTRL_SUB;   // SUB
      11'b10001010000: dec_ctrl = CTRL_AND;   // AND
      11'b10101010000: dec_ctrl = CTRL_OR;    // ORR
      11'b11111000010: dec_ctrl = CTRL_ADD;   // LDUR
      11'b11111000000: dec_ctrl = CTRL_ADD;   // STUR
      11'b1001000100?: dec_ctrl = CTRL_ADD;   // ADDI
      11'b1101000100?: dec_ctrl = CTRL_SUB;   // SUBI
      11'b110100101??: dec_ctrl = CTRL_PASSB; // MOVZ
      11'b10110100???: begin                  // CBZ
        dec_ctrl = CTRL_PASSB;
        dec_cbz  = 1'b1;
      end
      default:         dec_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!resetl) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = dec_legal ? EXEC : DONE;
      EXEC: if (cnt == 4'd0) next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: requests are only taken in IDLE and never during reset.
  always_comb begin
    in_ready = (state == IDLE) && resetl;
  end

  // Settle counter, ALU operand registers and captured result.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      cnt         <= 4'd0;
      cbz_q       <= 1'b0;
      ALUCtrl     <= CTRL_AND;
      AluA        <= '0;
      AluB        <= '0;
      Result      <= '0;
      ResultZero  <= 1'b0;
      BranchTaken <= 1'b0;
      Illegal     <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= (next_state == DONE);
      if (accept) begin
        if (dec_legal) begin
          // Legal op: launch the operands and start the settle window.
          ALUCtrl <= dec_ctrl;
          AluA    <= OpA;
          AluB    <= OpB;
          cbz_q   <= dec_cbz;
          cnt     <= SETTLE_INIT;
        end else begin
          // Illegal op: ALU buses untouched, report immediately.
          cbz_q       <= 1'b0;
          Result      <= '0;
          ResultZero  <= 1'b0;
          BranchTaken <= 1'b0;
          Illegal     <= 1'b1;
        end
      end else if (exec_done) begin
        Result      <= AluW;
        ResultZero  <= AluZero;
        BranchTaken <= cbz_q & AluZero;
        Illegal     <= 1'b0;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: self-checking bench for alu_issue_ctrl. A behavioural
// ALU sits on the ALU buses. The expected results come from an instruction-level
// model keyed by the decode table (mask/value patterns), and the bench also
// checks cycle latency and handshake timing.
module tb_alu_issue_ctrl;

  localparam int N      = 64;
  localparam int SETTLE = 1;

  logic         CLK = 1'b0;
  logic         resetl;
  logic         in_valid;
  logic         in_ready;
  logic [10:0]  Opcode;
  logic [N-1:0] OpA;
  logic [N-1:0] OpB;
  logic [3:0]   ALUCtrl;
  logic [N-1:0] AluA;
  logic [N-1:0] AluB;
  logic [N-1:0] AluW;
  logic         AluZero;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Result;
  logic         ResultZero;
  logic         BranchTaken;
  logic         Illegal;

  int checks = 0;
  int errors = 0;

  // Instruction table: kind index -> fixed opcode bits, don't-care mask, ctrl.
  // 0 ADD 1 SUB 2 AND 3 ORR 4 LDUR 5 STUR 6 ADDI 7 SUBI 8 MOVZ 9 CBZ
  logic [10:0] op_base [10];
  logic [10:0] op_mask [10];
  logic [3:0]  op_ctrl [10];

  // Model of what the ALU buses should currently hold.
  logic [3:0]   m_ctrl;
  logic [N-1:0] m_a;
  logic [N-1:0] m_b;

  alu_issue_ctrl #(.n(N), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready),
    .Opcode(Opcode), .OpA(OpA), .OpB(OpB), .ALUCtrl(ALUCtrl),
    .AluA(AluA), .AluB(AluB), .AluW(AluW), .AluZero(AluZero),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .ResultZero(ResultZero), .BranchTaken(BranchTaken), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  // Behavioural 64-bit ALU attached to the DUT's ALU buses.
  always_comb begin
    AluW = '0;
    case (ALUCtrl)
      4'b0000: AluW = AluA & AluB;
      4'b0001: AluW = AluA | AluB;
      4'b0010: AluW = AluA + AluB;
      4'b0110: AluW = AluA - AluB;
      4'b0111: AluW = AluB;
      default: AluW = '0;
    endcase
    AluZero = (AluW == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Returns the table kind an opcode matches, or -1 when not decodable.
  function automatic int kind_of(input logic [10:0] opc);
    for (int k = 0; k < 10; k++)
      if ((opc & ~op_mask[k]) == op_base[k]) return k;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_result(input int kind, input logic [N-1:0] a,
                                                input logic [N-1:0] b);
    case (kind)
      0, 4, 5, 6: return a + b;
      1, 7:       return a - b;
      2:          return a & b;
      3:          return a | b;
      default:    return b;
    endcase
  endfunction

  // One full transaction starting in IDLE: accept, wait for result, hold it
  // for 'hold' cycles with out_ready low, then retire it.
  task automatic run_op(input logic [10:0] opc, input logic [N-1:0] a,
                        input logic [N-1:0] b, input int hold);
    int           kind;
    int           lat;
    int           exp_lat;
    logic [N-1:0] exp_res;
    logic         exp_zero;
    logic         exp_br;
    logic         exp_ill;
    kind = kind_of(opc);
    if (kind >= 0) begin
      exp_res  = model_result(kind, a, b);
      exp_zero = (exp_res == '0);
      exp_br   = (kind == 9) && exp_zero;
      exp_ill  = 1'b0;
      exp_lat  = SETTLE + 1;
    end else begin
      exp_res  = '0;
      exp_zero = 1'b0;
      exp_br   = 1'b0;
      exp_ill  = 1'b1;
      exp_lat  = 1;
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    Opcode   = opc;
    OpA      = a;
    OpB      = b;
    step();
    in_valid = 1'b0;
    check("in_ready_busy", 64'(in_ready), 64'd0);
    if (kind >= 0) begin
      m_ctrl = op_ctrl[kind];
      m_a    = a;
      m_b    = b;
    end
    check("alu_ctrl", 64'(ALUCtrl), 64'(m_ctrl));
    check("alu_a", AluA, m_a);
    check("alu_b", AluB, m_b);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", Result, exp_res);
    check("result_zero", 64'(ResultZero), 64'(exp_zero));
    check("branch_taken", 64'(BranchTaken), 64'(exp_br));
    check("illegal", 64'(Illegal), 64'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", Result, exp_res);
      check("hold_zero", 64'(ResultZero), 64'(exp_zero));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_alu_a", AluA, m_a);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [10:0]  opc;
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           r;
    int           tries;

    op_base = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                11'b11111000010, 11'b11111000000, 11'b10010001000, 11'b11010001000,
                11'b11010010100, 11'b10110100000};
    op_mask = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd1, 11'd1, 11'd3, 11'd7};
    op_ctrl = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                4'b0110, 4'b0111, 4'b0111};

    resetl    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Opcode    = '0;
    OpA       = '0;
    OpB       = '0;
    m_ctrl    = 4'b0000;
    m_a       = '0;
    m_b       = '0;

    // Reset state.
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_alu_ctrl", 64'(ALUCtrl), 64'd0);
    check("rst_result", Result, 64'd0);
    check("rst_illegal", 64'(Illegal), 64'd0);
    resetl = 1'b1;
    #1;
    check("rst_release_ready", 64'(in_ready), 64'd1);

    // Reset while in EXEC abandons the request.
    in_valid = 1'b1;
    Opcode   = 11'b10001011000;
    OpA      = 64'd100;
    OpB      = 64'd23;
    step();
    in_valid = 1'b0;
    resetl   = 1'b0;
    step();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_alu_ctrl", 64'(ALUCtrl), 64'd0);
    check("midrst_alu_a", AluA, 64'd0);
    check("midrst_alu_b", AluB, 64'd0);
    check("midrst_result", Result, 64'd0);
    check("midrst_zero", 64'(ResultZero), 64'd0);
    resetl = 1'b1;
    step();
    step();
    check("midrst_no_output", 64'(out_valid), 64'd0);

    // Directed cases.
    run_op(11'b10001011000, 64'd5, 64'd7, 0);   // ADD 5+7
    run_op(11'b11001011000, 64'd9, 64'd9, 3);   // SUB 9-9, held 3 cycles
    run_op(11'b10110100101, 64'd77, 64'd0, 0);  // CBZ taken
    run_op(11'b10110100101, 64'd77, 64'd3, 1);  // CBZ not taken
    run_op(11'b00000000000, 64'd1, 64'd2, 2);   // illegal, ALU buses unchanged

    // Back-to-back ORR then AND with in_valid held high and out_ready=1.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    Opcode    = 11'b10101010000;
    OpA       = 64'hF0;
    OpB       = 64'h0F;
    step();
    Opcode = 11'b10001010000;
    check("b2b_exec_ready", 64'(in_ready), 64'd0);
    check("b2b_orr_ctrl", 64'(ALUCtrl), 64'b0001);
    step();
    check("b2b_orr_valid", 64'(out_valid), 64'd1);
    check("b2b_orr_result", Result, 64'hFF);
    check("b2b_orr_zero", 64'(ResultZero), 64'd0);
    check("b2b_done_ready", 64'(in_ready), 64'd0);
    step();
    check("b2b_idle_valid", 64'(out_valid), 64'd0);
    check("b2b_idle_ready", 64'(in_ready), 64'd1);
    check("b2b_no_done_accept", 64'(ALUCtrl), 64'b0001);
    step();
    in_valid = 1'b0;
    check("b2b_and_ready", 64'(in_ready), 64'd0);
    check("b2b_and_ctrl", 64'(ALUCtrl), 64'b0000);
    step();
    check("b2b_and_valid", 64'(out_valid), 64'd1);
    check("b2b_and_result", Result, 64'h0);
    check("b2b_and_zero", 64'(ResultZero), 64'd1);
    check("b2b_and_done_ready", 64'(in_ready), 64'd0);
    step();
    out_ready = 1'b0;
    check("b2b_final_valid", 64'(out_valid), 64'd0);
    m_ctrl = 4'b0000;
    m_a    = 64'hF0;
    m_b    = 64'h0F;

    // Randomized transactions across all instruction kinds plus illegal.
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 10);
      if (r < 10) begin
        opc = op_base[r] | (11'($urandom) & op_mask[r]);
      end else begin
        opc   = 11'($urandom);
        tries = 0;
        while (kind_of(opc) >= 0 && tries < 100) begin
          opc = 11'($urandom);
          tries++;
        end
        if (kind_of(opc) >= 0) opc = 11'b00000000000;
      end
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = '0;
        default: b = {$urandom, $urandom};
      endcase
      run_op(opc, a, b, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
